// File: rtl/alu_op_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_pkg
// Shared definitions for the ALU op sequencer: opcode and FSM state encodings,
// instruction field positions, default widths, and small decode helpers.
// -----------------------------------------------------------------------------
package alu_op_sequencer_pkg;

   localparam int DATA_W_DEF = 4;
   localparam int NREG_DEF   = 4;
   localparam int REG_AW     = 2;
   localparam int INSTR_W    = 9;

   // Instruction layout: {op[8:6], rd[5:4], rs1[3:2], rs2[1:0]}
   localparam int OP_MSB  = 8;
   localparam int OP_LSB  = 6;
   localparam int RD_MSB  = 5;
   localparam int RD_LSB  = 4;
   localparam int RS1_MSB = 3;
   localparam int RS1_LSB = 2;
   localparam int RS2_MSB = 1;
   localparam int RS2_LSB = 0;

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_ADD = 3'b001,
      OP_SUB = 3'b010,
      OP_AND = 3'b011,
      OP_OR  = 3'b100,
      OP_XOR = 3'b101,
      OP_LDI = 3'b110,
      OP_ILL = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_READ = 2'b01,
      S_EXEC = 2'b10,
      S_WB   = 2'b11
   } state_e;

   // One-hot unit enable vector, bit order {xor, or, and, sub, add}.
   function automatic logic [4:0] unit_enable(input op_e op);
      logic [4:0] en;
      case (op)
         OP_ADD:  en = 5'b00001;
         OP_SUB:  en = 5'b00010;
         OP_AND:  en = 5'b00100;
         OP_OR:   en = 5'b01000;
         OP_XOR:  en = 5'b10000;
         default: en = 5'b00000;
      endcase
      return en;
   endfunction

   // Ops that write back to the register file.
   function automatic logic op_writes(input op_e op);
      return (op != OP_NOP) && (op != OP_ILL);
   endfunction

endpackage

// File: rtl/alu_op_sequencer_regfile_4x4.sv
// -----------------------------------------------------------------------------
// regfile_4x4
// NREG x DATA_W register file with two combinational read ports, one
// combinational debug read port and one synchronous write port. Contents are
// cleared by the asynchronous active-low reset.
// Ports:
//   clk, rst_n        clock, async active-low clear
//   ra1/rd1, ra2/rd2  operand read ports
//   dbg_sel/dbg_data  debug read port
//   we, wa, wd        write enable, address, data (written on rising edge)
// -----------------------------------------------------------------------------
module regfile_4x4
   import alu_op_sequencer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREG   = NREG_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] ra1,
   input  logic [REG_AW-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic [REG_AW-1:0] dbg_sel,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              we,
   input  logic [REG_AW-1:0] wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];

   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[wa] = wd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads come from the flops, so a same-cycle write is seen one cycle later.
   assign rd1      = regs_q[ra1];
   assign rd2      = regs_q[ra2];
   assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Multi-cycle controller: accepts one register-to-register instruction per
// handshake, drives operands and a one-hot enable to the external ALU op units,
// captures their OR-combined result and writes it back to the register file.
// Sequence per instruction: IDLE -> READ -> EXEC -> WB -> IDLE.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   instr_valid/instr_ready    instruction handshake (ready only in IDLE)
//   instr[8:0]                 {op, rd, rs1, rs2}; LDI uses {rs1,rs2} as imm
//   Rd1, Rd2                   operands to the op units (registered)
//   en_add..en_xor             one-hot unit enables (registered)
//   alu_result                 OR of all unit outputs
//   done, err                  writeback pulse, illegal-op pulse
//   zero                       last written result was zero
//   dbg_sel/dbg_data           debug register read
// -----------------------------------------------------------------------------
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREG   = NREG_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   output logic [DATA_W-1:0]  Rd1,
   output logic [DATA_W-1:0]  Rd2,
   output logic               en_add,
   output logic               en_sub,
   output logic               en_and,
   output logic               en_or,
   output logic               en_xor,
   input  logic [DATA_W-1:0]  alu_result,
   output logic               done,
   output logic               err,
   output logic               zero,
   input  logic [REG_AW-1:0]  dbg_sel,
   output logic [DATA_W-1:0]  dbg_data
);

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [DATA_W-1:0]  rd1_q, rd1_d;
   logic [DATA_W-1:0]  rd2_q, rd2_d;
   logic [4:0]         en_q, en_d;
   logic [DATA_W-1:0]  result_q, result_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               zero_q, zero_d;

   logic [DATA_W-1:0]  rf_rd1, rf_rd2;
   logic               rf_we;
   op_e                op;
   logic [3:0]         imm;

   assign op  = op_e'(instr_q[OP_MSB:OP_LSB]);
   assign imm = instr_q[RS1_MSB:RS2_LSB];

   // Write happens on the edge that leaves WB, so dbg_data shows the old
   // value during WB and the new one afterwards.
   assign rf_we = (state_q == S_WB) && op_writes(op);

   regfile_4x4 #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra1      (instr_q[RS1_MSB:RS1_LSB]),
      .ra2      (instr_q[RS2_MSB:RS2_LSB]),
      .rd1      (rf_rd1),
      .rd2      (rf_rd2),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data),
      .we       (rf_we),
      .wa       (instr_q[RD_MSB:RD_LSB]),
      .wd       (result_q)
   );

   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      rd1_d    = rd1_q;
      rd2_d    = rd2_q;
      en_d     = en_q;
      result_d = result_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      zero_d   = zero_q;
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = S_READ;
            end
         end
         S_READ: begin
            // Operands are frozen here, so rd may alias rs1/rs2 safely.
            rd1_d   = rf_rd1;
            rd2_d   = rf_rd2;
            en_d    = unit_enable(op);
            state_d = S_EXEC;
         end
         S_EXEC: begin
            result_d = (op == OP_LDI) ? DATA_W'(imm) : alu_result;
            en_d     = '0;
            done_d   = 1'b1;
            err_d    = (op == OP_ILL);
            state_d  = S_WB;
         end
         S_WB: begin
            if (op_writes(op)) begin
               zero_d = (result_q == '0);
            end
            rd1_d   = '0;
            rd2_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         instr_q  <= '0;
         rd1_q    <= '0;
         rd2_q    <= '0;
         en_q     <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         rd1_q    <= rd1_d;
         rd2_q    <= rd2_d;
         en_q     <= en_d;
         result_q <= result_d;
         done_q   <= done_d;
         err_q    <= err_d;
         zero_q   <= zero_d;
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign Rd1         = rd1_q;
   assign Rd2         = rd2_q;
   assign en_add      = en_q[0];
   assign en_sub      = en_q[1];
   assign en_and      = en_q[2];
   assign en_or       = en_q[3];
   assign en_xor      = en_q[4];
   assign done        = done_q;
   assign err         = err_q;
   assign zero        = zero_q;

endmodule
